// File: rtl/obi_apb_splitter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_apb_splitter_pkg                                          |
// | Purpose  : Shared types and the address-decode helper for the OBI-to-APB |
// |            splitter. Provides the FSM state enum, the decode result      |
// |            struct and decode_addr(), which maps an OBI address onto one  |
// |            of N equally sized, contiguous target windows.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package obi_apb_splitter_pkg;

   // Widest target index the splitter supports (up to 16 targets).
   localparam int unsigned c_idx_w_max = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   typedef struct packed {
      logic                   hit;
      logic [c_idx_w_max-1:0] idx;
   } decode_t;

   // Window i covers [base + i*size, base + (i+1)*size). The arithmetic is
   // done at 64 bits so the window end never wraps for any supported
   // address width; the caller zero-extends the OBI address.
   function automatic decode_t decode_addr(
      input logic [63:0] addr,
      input logic [63:0] base,
      input logic [63:0] size,
      input int unsigned n
   );
      decode_t     d;
      logic [63:0] limit;
      limit = base + (64'(n) * size);
      d.hit = (addr >= base) && (addr < limit);
      d.idx = d.hit ? c_idx_w_max'((addr - base) / size) : '0;
      return d;
   endfunction

endpackage : obi_apb_splitter_pkg
`default_nettype wire

// File: rtl/obi_apb_splitter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_apb_splitter_if                                           |
// | Purpose  : Bundles the OBI subordinate port, the shared/per-target APB   |
// |            requester signals and the per-target enable vector of the     |
// |            splitter.                                                     |
// |            slave  : view taken by the splitter (OBI subordinate side,    |
// |                     APB requester side)                                  |
// |            master : view taken by the surrounding system (issues OBI     |
// |                     requests, answers as the APB targets)                |
// | Ports    : obi_* request/response channel with parity companions,        |
// |            ss_ctrl_icn target enables, apb_* shared address/data/control |
// |            plus one-hot psel and per-target prdata/pready/pslverr.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface obi_apb_splitter_if
   import obi_apb_splitter_pkg::*;
#(
   parameter int unsigned N_TARGETS = 4,
   parameter int unsigned OBI_AW    = 32,
   parameter int unsigned OBI_DW    = 32,
   parameter int unsigned OBI_IDW   = 1,
   parameter int unsigned APB_AW    = 32,
   parameter int unsigned APB_DW    = 32,
   parameter int unsigned SS_CTRL_W = 7
);
   // OBI request channel
   logic                        obi_req;
   logic                        obi_reqpar;
   logic                        obi_gnt;
   logic                        obi_gntpar;
   logic [OBI_AW-1:0]           obi_addr;
   logic                        obi_we;
   logic [OBI_DW/8-1:0]         obi_be;
   logic [OBI_DW-1:0]           obi_wdata;
   logic [OBI_IDW-1:0]          obi_aid;
   // OBI response channel
   logic                        obi_rvalid;
   logic                        obi_rvalidpar;
   logic                        obi_rready;
   logic                        obi_rreadypar;
   logic [OBI_DW-1:0]           obi_rdata;
   logic [OBI_IDW-1:0]          obi_rid;
   logic                        obi_err;
   // Target enables
   logic [SS_CTRL_W-1:0]        ss_ctrl_icn;
   // APB requester side
   logic [APB_AW-1:0]           apb_paddr;
   logic                        apb_pwrite;
   logic [APB_DW-1:0]           apb_pwdata;
   logic [APB_DW/8-1:0]         apb_pstrb;
   logic                        apb_penable;
   logic [N_TARGETS-1:0]        apb_psel;
   logic [N_TARGETS*APB_DW-1:0] apb_prdata;
   logic [N_TARGETS-1:0]        apb_pready;
   logic [N_TARGETS-1:0]        apb_pslverr;

   modport slave (
      input  obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
      input  obi_rready, obi_rreadypar, ss_ctrl_icn,
      input  apb_prdata, apb_pready, apb_pslverr,
      output obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid,
      output obi_err,
      output apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_penable, apb_psel
   );

   modport master (
      output obi_req, obi_reqpar, obi_addr, obi_we, obi_be, obi_wdata, obi_aid,
      output obi_rready, obi_rreadypar, ss_ctrl_icn,
      output apb_prdata, apb_pready, apb_pslverr,
      input  obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar, obi_rdata, obi_rid,
      input  obi_err,
      input  apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_penable, apb_psel
   );

endinterface : obi_apb_splitter_if
`default_nettype wire

// File: rtl/obi_apb_timeout_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_apb_timeout_cnt                                           |
// | Purpose  : Counts APB ACCESS cycles and flags the cycle in which the     |
// |            transfer must be abandoned. o_expire is high during the       |
// |            TIMEOUT_CYCLES-th consecutive enabled cycle, so an ACCESS     |
// |            phase lasts at most TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 |
// |            removes the counter and ties o_expire low.                    |
// | Ports    : clk, reset_n (sync, active low), i_clear (priority clear),    |
// |            i_enable (count this cycle), o_expire (limit reached).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module obi_apb_timeout_cnt
   import obi_apb_splitter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
)(
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         logic w_unused;
         assign w_unused = ^{clk, reset_n, i_clear, i_enable};
         assign o_expire = 1'b0;
      end else begin : g_enabled
         localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

         logic [c_cnt_w-1:0] r_cnt;

         always_ff @(posedge clk) begin
            if (!reset_n || i_clear) begin
               r_cnt <= '0;
            end else if (i_enable) begin
               r_cnt <= r_cnt + c_cnt_w'(1);
            end
         end

         // r_cnt holds the number of enabled cycles already elapsed, so the
         // current cycle is the last allowed one when it equals limit-1.
         assign o_expire = i_enable && (r_cnt == c_last);
      end
   endgenerate

endmodule : obi_apb_timeout_cnt
`default_nettype wire

// File: rtl/obi_apb_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obi_apb_splitter                                              |
// | Purpose  : Bridges one OBI subordinate port onto N_TARGETS APB requester |
// |            ports. Target i owns [ADDR_BASE + i*SS_SIZE, +SS_SIZE). One   |
// |            transaction is outstanding at a time; unmapped or disabled    |
// |            addresses and PREADY timeouts return an OBI error response.   |
// | Ports    : clk, reset_n (synchronous, active low)                        |
// |            bus (obi_apb_splitter_if.slave): OBI req/gnt/r-channel,       |
// |            ss_ctrl_icn target enables, shared APB address/data/control,  |
// |            one-hot apb_psel and per-target prdata/pready/pslverr.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module obi_apb_splitter
   import obi_apb_splitter_pkg::*;
#(
   parameter int unsigned N_TARGETS      = 4,
   parameter int unsigned OBI_AW         = 32,
   parameter int unsigned OBI_DW         = 32,
   parameter int unsigned OBI_IDW        = 1,
   parameter int unsigned APB_AW         = 32,
   parameter int unsigned APB_DW         = 32,
   parameter logic [63:0] ADDR_BASE      = 64'h0105_0000,
   parameter logic [63:0] SS_SIZE        = 64'h1000,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned SS_CTRL_W      = 7
)(
   input  logic              clk,
   input  logic              reset_n,
   obi_apb_splitter_if.slave bus
);

   localparam int unsigned c_idx_w = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

   localparam logic [1:0] c_st_idle   = ST_IDLE;
   localparam logic [1:0] c_st_setup  = ST_SETUP;
   localparam logic [1:0] c_st_access = ST_ACCESS;
   localparam logic [1:0] c_st_resp   = ST_RESP;

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   logic [1:0]           r_state;
   logic [c_idx_w-1:0]   r_idx;
   logic [N_TARGETS-1:0] r_psel;
   logic                 r_penable;
   logic                 r_pwrite;
   logic [APB_AW-1:0]    r_paddr;
   logic [APB_DW-1:0]    r_pwdata;
   logic [APB_DW/8-1:0]  r_pstrb;
   logic [OBI_DW-1:0]    r_rdata;
   logic                 r_err;
   logic [OBI_IDW-1:0]   r_rid;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   decode_t              w_dec;
   logic [c_idx_w-1:0]   w_dec_idx;
   logic [N_TARGETS-1:0] w_dec_onehot;
   logic                 w_target_en;
   logic                 w_gnt;
   logic                 w_in_access;
   logic                 w_expire;
   logic                 w_sel_ready;
   logic                 w_sel_err;
   logic [APB_DW-1:0]    w_sel_rdata;
   logic [APB_DW-1:0]    w_prdata [N_TARGETS];
   logic                 w_unused;

   generate
      for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_prdata
         assign w_prdata[gi] = bus.apb_prdata[gi*APB_DW +: APB_DW];
      end
   endgenerate

   assign w_dec       = decode_addr(64'(bus.obi_addr), ADDR_BASE, SS_SIZE, N_TARGETS);
   assign w_dec_idx   = w_dec.idx[c_idx_w-1:0];
   assign w_target_en = bus.ss_ctrl_icn[w_dec_idx];

   always_comb begin
      w_dec_onehot            = '0;
      w_dec_onehot[w_dec_idx] = 1'b1;
   end

   // Grant is a pure function of req while idle; reset masks it so nothing
   // can be accepted in the cycle the block is being cleared.
   assign w_gnt = reset_n && (r_state == c_st_idle) && bus.obi_req;

   // Only the target latched at decode is looked at; the other targets'
   // ready/error lines are don't-care.
   assign w_sel_ready = bus.apb_pready[r_idx];
   assign w_sel_err   = bus.apb_pslverr[r_idx];
   assign w_sel_rdata = w_prdata[r_idx];

   assign w_in_access = (r_state == c_st_access);

   obi_apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clear  (!w_in_access),
      .i_enable (w_in_access),
      .o_expire (w_expire)
   );

   // ------------------------------------------------------------------
   // Transfer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= c_st_idle;
         r_idx     <= '0;
         r_psel    <= '0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_rid     <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_gnt) begin
                  r_rid <= bus.obi_aid;
                  if (w_dec.hit && w_target_en) begin
                     r_idx     <= w_dec_idx;
                     r_psel    <= w_dec_onehot;
                     r_penable <= 1'b0;
                     r_paddr   <= bus.obi_addr[APB_AW-1:0];
                     r_pwrite  <= bus.obi_we;
                     r_pwdata  <= bus.obi_wdata;
                     r_pstrb   <= bus.obi_we ? bus.obi_be : '0;
                     r_state   <= c_st_setup;
                  end else begin
                     // Unmapped or disabled: answer immediately, no APB cycle.
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                     r_state <= c_st_resp;
                  end
               end
            end

            c_st_setup: begin
               r_penable <= 1'b1;
               r_state   <= c_st_access;
            end

            c_st_access: begin
               // A ready arriving in the final allowed cycle still completes
               // the transfer normally.
               if (w_sel_ready) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_rdata   <= r_pwrite ? '0 : w_sel_rdata;
                  r_err     <= w_sel_err;
                  r_state   <= c_st_resp;
               end else if (w_expire) begin
                  r_psel    <= '0;
                  r_penable <= 1'b0;
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_state   <= c_st_resp;
               end
            end

            c_st_resp: begin
               if (bus.obi_rready) begin
                  r_state <= c_st_idle;
               end
            end

            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign bus.obi_gnt       = w_gnt;
   assign bus.obi_gntpar    = ~w_gnt;
   assign bus.obi_rvalid    = (r_state == c_st_resp);
   assign bus.obi_rvalidpar = ~(r_state == c_st_resp);
   assign bus.obi_rdata     = r_rdata;
   assign bus.obi_rid       = r_rid;
   assign bus.obi_err       = r_err;

   assign bus.apb_paddr     = r_paddr;
   assign bus.apb_pwrite    = r_pwrite;
   assign bus.apb_pwdata    = r_pwdata;
   assign bus.apb_pstrb     = r_pstrb;
   assign bus.apb_penable   = r_penable;
   assign bus.apb_psel      = r_psel;

   // Parity inputs are not checked and enable bits above N_TARGETS are
   // reserved; decode index bits beyond the target count are always zero.
   assign w_unused = ^{bus.obi_reqpar, bus.obi_rreadypar, bus.ss_ctrl_icn, w_dec};

endmodule : obi_apb_splitter
`default_nettype wire

// File: tb/tb_obi_apb_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_obi_apb_splitter                                           |
// | Purpose  : Self-checking bench for obi_apb_splitter. Directed cases and  |
// |            randomized OBI traffic; a reference model predicts the OBI    |
// |            response and the APB transfer of every accepted request,      |
// |            monitors compare what the DUT presents.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_obi_apb_splitter;

   localparam int unsigned NT   = 4;
   localparam int unsigned TO   = 8;
   localparam longint unsigned BASE = 64'h0105_0000;
   localparam longint unsigned SIZE = 64'h1000;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        rid;
      int          gcyc;
      int          lat;
   } exp_t;

   typedef struct {
      logic [3:0]  psel;
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      int          waits;
      bit          hang;
      logic [31:0] prdata;
      logic        slverr;
   } apb_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   force_hold = 0;
   exp_t exp_q[$];
   apb_t apb_q[$];

   obi_apb_splitter_if #(.N_TARGETS(NT)) bus ();

   obi_apb_splitter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_gnt",       bus.obi_gnt, 0);
      chk("rst_gntpar",    bus.obi_gntpar, 1);
      chk("rst_rvalid",    bus.obi_rvalid, 0);
      chk("rst_rvalidpar", bus.obi_rvalidpar, 1);
      chk("rst_err",       bus.obi_err, 0);
      chk("rst_rdata",     bus.obi_rdata, 0);
      chk("rst_rid",       bus.obi_rid, 0);
      chk("rst_psel",      bus.apb_psel, 0);
      chk("rst_penable",   bus.apb_penable, 0);
      chk("rst_pwrite",    bus.apb_pwrite, 0);
      chk("rst_paddr",     bus.apb_paddr, 0);
      chk("rst_pwdata",    bus.apb_pwdata, 0);
      chk("rst_pstrb",     bus.apb_pstrb, 0);
   endtask

   // ------------------------------------------------------------------
   // OBI response monitor (also drives rready)
   // ------------------------------------------------------------------
   initial begin
      bit          in_resp = 0;
      logic [31:0] h_rdata = '0;
      logic        h_err = 0, h_rid = 0;
      exp_t        e;
      bus.obi_rready    = 1'b1;
      bus.obi_rreadypar = 1'b0;
      forever begin
         @(negedge clk);
         bus.obi_rreadypar = 1'($urandom);
         if (reset_n && bus.obi_rvalid) begin
            if (!in_resp) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_rvalid: got rvalid with no outstanding request (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("rdata",   bus.obi_rdata, e.rdata);
                  chk("err",     bus.obi_err, e.err);
                  chk("rid",     bus.obi_rid, e.rid);
                  chk("latency", cyc - e.gcyc, e.lat);
               end
               h_rdata = bus.obi_rdata;
               h_err   = bus.obi_err;
               h_rid   = bus.obi_rid;
               in_resp = 1;
            end else begin
               chk("rdata_stable", bus.obi_rdata, h_rdata);
               chk("err_stable",   bus.obi_err, h_err);
               chk("rid_stable",   bus.obi_rid, h_rid);
            end
            chk("gnt_in_resp",  bus.obi_gnt, 0);
            chk("psel_in_resp", bus.apb_psel, 0);
            chk("rvalidpar",    bus.obi_rvalidpar, 0);
            if (force_hold > 0) begin
               bus.obi_rready = 1'b0;
               force_hold--;
            end else begin
               bus.obi_rready = ($urandom_range(0, 3) != 0);
            end
            if (bus.obi_rready) in_resp = 0;
         end else begin
            in_resp = 0;
            bus.obi_rready = 1'($urandom);
         end
      end
   end

   // ------------------------------------------------------------------
   // APB target model and APB monitor
   // ------------------------------------------------------------------
   initial begin
      apb_t        cur;
      bit          have = 0;
      int          acnt = 0;
      bit          rdy;
      logic [31:0] noise;
      cur = '{default: '0};
      bus.apb_pready  = '0;
      bus.apb_pslverr = '0;
      bus.apb_prdata  = '0;
      forever begin
         @(negedge clk);
         if (bus.apb_psel != 0 && !bus.apb_penable) begin
            n_checks++;
            if (apb_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_psel: got psel %0h with no mapped request (cycle %0d)", bus.apb_psel, cyc);
               have = 0;
            end else begin
               cur = apb_q.pop_front();
               chk("psel",   bus.apb_psel, cur.psel);
               chk("paddr",  bus.apb_paddr, cur.paddr);
               chk("pwrite", bus.apb_pwrite, cur.pwrite);
               chk("pwdata", bus.apb_pwdata, cur.pwdata);
               chk("pstrb",  bus.apb_pstrb, cur.pstrb);
               have = 1;
            end
            acnt = 0;
         end else if (bus.apb_psel != 0 && bus.apb_penable) begin
            acnt++;
            if (have) chk("psel_access", bus.apb_psel, cur.psel);
         end else begin
            acnt = 0;
            have = 0;
         end
         rdy   = have && bus.apb_penable && !cur.hang && (acnt > cur.waits);
         noise = $urandom;
         bus.apb_pready  = (noise[3:0] & ~bus.apb_psel) | (rdy ? bus.apb_psel : 4'b0);
         bus.apb_pslverr = (noise[7:4] & ~bus.apb_psel) | ((have && cur.slverr) ? bus.apb_psel : 4'b0);
         for (int i = 0; i < NT; i++) begin
            bus.apb_prdata[i*32 +: 32] = (have && bus.apb_psel[i]) ? cur.prdata : $urandom;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus: one OBI request; the model decides the expected outcome
   // from the enable vector present at the grant.
   // ------------------------------------------------------------------
   task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic aid, input logic [6:0] ctrl,
                        input int waits, input bit hang, input logic [31:0] prdata,
                        input logic slverr, input int hold, input bit rst_abort,
                        input bit rand_ctrl);
      longint unsigned a;
      bit   hit, mapped, granted;
      int   tgt, tries;
      exp_t e;
      apb_t p;
      bus.obi_req     = 1'b1;
      bus.obi_addr    = addr;
      bus.obi_we      = we;
      bus.obi_be      = be;
      bus.obi_wdata   = wdata;
      bus.obi_aid     = aid;
      bus.ss_ctrl_icn = ctrl;
      granted = 0;
      tries   = 0;
      while (!granted && tries < 200) begin
         #1;
         if (bus.obi_gnt) begin
            granted = 1;
         end else begin
            @(negedge clk);
            tries++;
            bus.obi_reqpar = 1'($urandom);
            if (rand_ctrl) bus.ss_ctrl_icn = 7'($urandom | $urandom);
         end
      end
      n_checks++;
      if (!granted) begin
         n_errors++;
         $display("FAIL grant_timeout: got no grant, required one within 200 cycles (addr %0h)", addr);
         bus.obi_req = 1'b0;
         return;
      end
      chk("gntpar", bus.obi_gntpar, 0);
      a      = addr;
      hit    = (a >= BASE) && (a < BASE + NT * SIZE);
      tgt    = hit ? int'((a - BASE) / SIZE) : 0;
      mapped = hit && bus.ss_ctrl_icn[tgt];
      e.gcyc = cyc;
      e.rid  = aid;
      if (!mapped) begin
         e.rdata = '0; e.err = 1'b1; e.lat = 1;
      end else if (hang) begin
         e.rdata = '0; e.err = 1'b1; e.lat = 2 + TO;
      end else begin
         e.rdata = we ? 32'h0 : prdata; e.err = slverr; e.lat = 3 + waits;
      end
      if (mapped) begin
         p.psel = 4'(1 << tgt); p.paddr = addr; p.pwrite = we; p.pwdata = wdata;
         p.pstrb = we ? be : 4'b0; p.waits = waits; p.hang = hang;
         p.prdata = prdata; p.slverr = slverr;
         apb_q.push_back(p);
      end
      if (!rst_abort) exp_q.push_back(e);
      force_hold = hold;
      @(posedge clk);
      @(negedge clk);
      bus.obi_req   = 1'b0;
      bus.obi_addr  = $urandom;
      bus.obi_wdata = $urandom;
      if (rst_abort) begin
         tries = 0;
         while (!bus.apb_penable && tries < 5) begin
            @(negedge clk);
            tries++;
         end
         chk("access_before_reset", bus.apb_penable, 1);
         reset_n     = 1'b0;
         bus.obi_req = 1'b1;
         @(negedge clk);
         check_reset_outputs();
         reset_n     = 1'b1;
         bus.obi_req = 1'b0;
      end
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      logic [31:0] addr;
      int          kind;
      bus.obi_req = 1'b1; bus.obi_reqpar = 1'b0; bus.obi_addr = BASE[31:0];
      bus.obi_we = 1'b0; bus.obi_be = 4'hF; bus.obi_wdata = '0; bus.obi_aid = 1'b0;
      bus.ss_ctrl_icn = 7'h7F;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset_n = 1'b1;
      bus.obi_req = 1'b0;
      @(negedge clk);

      // Read from target 2, zero wait states
      issue(32'h0105_2004, 0, 4'hF, 32'h0, 1, 7'h7F, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      // Write with two wait states
      issue(32'h0105_0010, 1, 4'b0011, 32'h1234_5678, 0, 7'h7F, 2, 0, 32'h0, 0, 0, 0, 0);
      // Below window, above window, disabled target 1
      issue(32'h0104_FFFC, 0, 4'hF, 32'h0, 1, 7'h7F, 0, 0, 32'h5555_5555, 0, 0, 0, 0);
      issue(32'h0105_4000, 0, 4'hF, 32'h0, 0, 7'h7F, 0, 0, 32'h5555_5555, 0, 0, 0, 0);
      issue(32'h0105_1000, 0, 4'hF, 32'h0, 1, 7'h7D, 0, 0, 32'h5555_5555, 0, 0, 0, 0);
      // Target 3 never ready, then a normal read to target 0
      issue(32'h0105_3ABC, 0, 4'hF, 32'h0, 1, 7'h7F, 0, 1, 32'h0, 0, 0, 0, 0);
      issue(32'h0105_0000, 0, 4'hF, 32'h0, 0, 7'h7F, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0);
      // Slave error from target 1 with rready held low
      issue(32'h0105_1008, 0, 4'hF, 32'h0, 1, 7'h7F, 1, 0, 32'hA5A5_0F0F, 1, 3, 0, 0);
      // Reset in the middle of ACCESS, then a standard read to target 0
      issue(32'h0105_0100, 0, 4'hF, 32'h0, 1, 7'h7F, 0, 1, 32'h0, 0, 0, 1, 0);
      issue(32'h0105_0104, 0, 4'hF, 32'h0, 1, 7'h7F, 0, 0, 32'h0BAD_CAFE, 0, 0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0:       addr = 32'(BASE - 4 * $urandom_range(1, 1000));
            1:       addr = 32'(BASE + NT * SIZE + 4 * $urandom_range(0, 1000));
            2:       addr = $urandom;
            default: addr = 32'(BASE + $urandom_range(0, NT - 1) * SIZE + 4 * $urandom_range(0, 1023));
         endcase
         issue(addr, 1'($urandom), 4'($urandom), $urandom, 1'($urandom),
               7'($urandom | $urandom), $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
               $urandom, ($urandom_range(0, 3) == 0), 0, 0, 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("responses_outstanding", exp_q.size(), 0);
      chk("apb_outstanding", apb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_obi_apb_splitter
`default_nettype wire
